// File: rtl/tone_period_detector.sv
// rtl/tone_period_detector.sv - recovers tone half-period from a PWM-chopped square wave
// Optional TONE_DETECT_STABLE_EN: accept only periods within +/-1 of the previous one.
module tone_period_detector #(
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 33554431
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        square_wave_in,
    output logic [23:0] tone_switch_period,
    output logic        period_valid,
    output logic        tone_present
);
    localparam logic [7:0]  GAP_VAL     = 8'(GAP_CYCLES);
    localparam logic [25:0] TIMEOUT_VAL = 26'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_TRACK
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q;
    logic [7:0]  low_run_q, low_run_d;
    logic        env_q, env_d;
    logic        env_dly_q;
    logic [25:0] pcnt_q, pcnt_d;
    logic [23:0] period_q, period_d;
    logic        valid_q, valid_d;

    logic        env_rise;
    logic        timeout;
    logic [23:0] h_meas;
    logic        h_ok;

    assign env_rise = env_q & ~env_dly_q;
    assign timeout  = (pcnt_q == TIMEOUT_VAL);
    // Accepted periods are below 2^25, so bits [24:1] hold the whole half-period.
    assign h_meas   = pcnt_q[24:1];

`ifdef TONE_DETECT_STABLE_EN
    logic [23:0] h_prev_q, h_prev_d;
    logic        h_prev_vld_q, h_prev_vld_d;
    logic [23:0] h_diff;

    assign h_diff = (h_meas >= h_prev_q) ? (h_meas - h_prev_q) : (h_prev_q - h_meas);
    assign h_ok   = h_prev_vld_q && (h_diff <= 24'd1);
`else
    assign h_ok   = 1'b1;
`endif

    // Low runs shorter than GAP_CYCLES are PWM chop and never drop the envelope.
    always_comb begin
        low_run_d = low_run_q;
        env_d     = env_q;
        if (sync2_q) begin
            low_run_d = 8'd0;
            env_d     = 1'b1;
        end else begin
            if (low_run_q != 8'hFF) begin
                low_run_d = low_run_q + 8'd1;
            end
            if (low_run_d >= GAP_VAL) begin
                env_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        valid_d  = 1'b0;
`ifdef TONE_DETECT_STABLE_EN
        h_prev_d     = h_prev_q;
        h_prev_vld_d = h_prev_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef TONE_DETECT_STABLE_EN
                h_prev_vld_d = 1'b0;
`endif
                if (env_rise) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED, S_TRACK: begin
                if (env_rise && timeout) begin
                    state_d = S_ARMED;
`ifdef TONE_DETECT_STABLE_EN
                    h_prev_vld_d = 1'b0;
`endif
                end else if (env_rise) begin
`ifdef TONE_DETECT_STABLE_EN
                    h_prev_d     = h_meas;
                    h_prev_vld_d = 1'b1;
`endif
                    if (h_ok) begin
                        state_d  = S_TRACK;
                        period_d = h_meas;
                        valid_d  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
`ifdef TONE_DETECT_STABLE_EN
                    h_prev_vld_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (env_rise) begin
            pcnt_d = 26'd1;
        end else if (state_d == S_IDLE) begin
            pcnt_d = 26'd0;
        end else if (!timeout) begin
            pcnt_d = pcnt_q + 26'd1;
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            low_run_q <= 8'd0;
            env_q     <= 1'b0;
            env_dly_q <= 1'b0;
            pcnt_q    <= 26'd0;
            period_q  <= 24'd0;
            valid_q   <= 1'b0;
`ifdef TONE_DETECT_STABLE_EN
            h_prev_q     <= 24'd0;
            h_prev_vld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= square_wave_in;
            sync2_q   <= sync1_q;
            low_run_q <= low_run_d;
            env_q     <= env_d;
            env_dly_q <= env_q;
            pcnt_q    <= pcnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
`ifdef TONE_DETECT_STABLE_EN
            h_prev_q     <= h_prev_d;
            h_prev_vld_q <= h_prev_vld_d;
`endif
        end
    end

    assign tone_switch_period = period_q;
    assign period_valid       = valid_q;
    assign tone_present       = (state_q == S_TRACK);

endmodule
